// File: rtl/kairo_fetch.sv
// kairo_fetch: RV32 instruction fetch stage with a 2-entry word/PC buffer; define KAIRO_FETCH_MISALIGN_EN to report misaligned redirect targets as faults.
module kairo_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_misalign,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  logic [1:0]  state;
  logic [31:0] pc, tgt_q, tgt_in, apply_tgt;
  logic        pend, apply, mis, push, pop;
  logic [1:0]  cnt;
  logic        rd, wr;
  logic [65:0] mem [2];
  logic [65:0] head;
`ifdef KAIRO_FETCH_MISALIGN_EN
  assign tgt_in = redirect_pc;
  assign mis = apply_tgt[1:0] != 2'b00;
`else
  assign tgt_in = redirect_pc & 32'hFFFF_FFFC;
  assign mis = 1'b0;
`endif
  // A held request stays asserted until acked; new requests only start from registered count
  assign ibus_req = rst_n & (state == DRAIN | (state == FETCH & (pend | cnt != 2'd2)));
  assign ibus_addr = {pc[31:2], 2'b00};
  // Redirects load the PC immediately unless a request is still in flight, which is drained first
  assign apply = (redirect_valid & (state == HALT | (state == FETCH & ~(ibus_req & ~ibus_ack))))
               | (state == DRAIN & ibus_ack);
  assign apply_tgt = redirect_valid ? tgt_in : tgt_q;
  assign push = state == FETCH & ibus_req & ibus_ack;
  assign pop = inst_valid & inst_ready;
  assign head = mem[rd];
  assign inst_valid = cnt != 2'd0;
  assign {inst_code, inst_pc, inst_fault, inst_misalign} = inst_valid ? head : 66'd0;
  // Fetch FSM, PC and buffer update; redirect outranks any coincident push or pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_VECTOR;
      tgt_q <= RESET_VECTOR;
      pend <= 1'b0;
      cnt <= 2'd0;
      rd <= 1'b0;
      wr <= 1'b0;
    end else begin
      pend <= ibus_req & ~ibus_ack;
      if (apply) begin
        pc <= apply_tgt;
        state <= mis ? HALT : FETCH;
        mem[0] <= {32'h0, apply_tgt, 1'b0, mis};
        cnt <= {1'b0, mis};
        wr <= mis;
        rd <= 1'b0;
      end else if (state == FETCH && redirect_valid) begin
        tgt_q <= tgt_in;
        state <= DRAIN;
        cnt <= 2'd0;
        rd <= 1'b0;
        wr <= 1'b0;
      end else if (state == DRAIN) begin
        if (redirect_valid) tgt_q <= tgt_in;
      end else begin
        if (push) begin
          mem[wr] <= ibus_err ? {32'h0, pc, 1'b1, 1'b0} : {ibus_rdata, pc, 1'b0, 1'b0};
          wr <= ~wr;
          if (ibus_err) state <= HALT;
          else pc <= pc + 32'd4;
        end
        if (pop) rd <= ~rd;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end
endmodule

// File: tb/tb_kairo_fetch.sv
// tb_kairo_fetch: directed checks of fetch stage sequencing, backpressure, redirect drain, faults and PC wrap.
module tb_kairo_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b1, ack_en = 1'b1, err_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic inst_valid, inst_fault, inst_misalign, ibus_req, ibus_ack, ibus_err;
  logic [31:0] inst_code, inst_pc, ibus_addr, ibus_rdata;
  logic w_valid, w_fault, w_misalign, w_req;
  logic [31:0] w_code, w_pc, w_addr;
  int checks = 0, errors = 0;
  assign ibus_ack = ibus_req & ack_en;
  assign ibus_rdata = ~ibus_addr;
  assign ibus_err = err_en;
  kairo_fetch #(.RESET_VECTOR(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .inst_misalign(inst_misalign), .ibus_req(ibus_req),
    .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err));
  kairo_fetch #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_ready(1'b1), .inst_valid(w_valid), .inst_code(w_code), .inst_pc(w_pc),
    .inst_fault(w_fault), .inst_misalign(w_misalign), .ibus_req(w_req),
    .ibus_addr(w_addr), .ibus_ack(w_req), .ibus_rdata(~w_addr), .ibus_err(1'b0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step;
    step;
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, ibus_req}, 32'd0);
    chk("rst_addr", ibus_addr, 32'h0000_1000);
    chk("rst_pc", inst_pc, 32'd0);
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    do_reset;
    chk("first_req", {31'd0, ibus_req}, 32'd1);
    chk("first_addr", ibus_addr, 32'h0000_1000);
    chk("wrap_addr", w_addr, 32'hFFFF_FFF8);
    step;
    chk("seq_valid0", {31'd0, inst_valid}, 32'd1);
    chk("seq_pc0", inst_pc, 32'h0000_1000);
    chk("seq_code0", inst_code, ~32'h0000_1000);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    step;
    chk("seq_pc1", inst_pc, 32'h0000_1004);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    step;
    chk("seq_pc2", inst_pc, 32'h0000_1008);
    chk("seq_code2", inst_code, ~32'h0000_1008);
    chk("wrap_pc2", w_pc, 32'h0000_0000);
    chk("wrap_code2", w_code, 32'hFFFF_FFFF);
    inst_ready = 1'b0;
    do_reset;
    repeat (5) step;
    chk("bp_req", {31'd0, ibus_req}, 32'd0);
    chk("bp_pc0", inst_pc, 32'h0000_1000);
    inst_ready = 1'b1;
    step;
    chk("bp_pc1", inst_pc, 32'h0000_1004);
    chk("bp_code1", inst_code, ~32'h0000_1004);
    chk("bp_req_resume", {31'd0, ibus_req}, 32'd1);
    chk("bp_addr_resume", ibus_addr, 32'h0000_1008);
    step;
    chk("bp_pc2", inst_pc, 32'h0000_1008);
    ack_en = 1'b0;
    do_reset;
    step;
    chk("rd_addr_wait", ibus_addr, 32'h0000_1000);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    step;
    redirect_valid = 1'b0;
    chk("rd_req_held", {31'd0, ibus_req}, 32'd1);
    chk("rd_addr_held", ibus_addr, 32'h0000_1000);
    chk("rd_valid_flush", {31'd0, inst_valid}, 32'd0);
    step;
    chk("rd_addr_held2", ibus_addr, 32'h0000_1000);
    ack_en = 1'b1;
    step;
    chk("rd_discard", {31'd0, inst_valid}, 32'd0);
    chk("rd_new_addr", ibus_addr, 32'h0000_2000);
    step;
    chk("rd_new_pc", inst_pc, 32'h0000_2000);
    chk("rd_new_code", inst_code, ~32'h0000_2000);
    do_reset;
    step;
    step;
    chk("flt_addr", ibus_addr, 32'h0000_1008);
    err_en = 1'b1;
    step;
    err_en = 1'b0;
    chk("flt_valid", {31'd0, inst_valid}, 32'd1);
    chk("flt_fault", {31'd0, inst_fault}, 32'd1);
    chk("flt_code", inst_code, 32'd0);
    chk("flt_pc", inst_pc, 32'h0000_1008);
    chk("flt_req", {31'd0, ibus_req}, 32'd0);
    step;
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    chk("halt_zero_pc", inst_pc, 32'd0);
    chk("halt_zero_fault", {31'd0, inst_fault}, 32'd0);
    step;
    chk("halt_req", {31'd0, ibus_req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    step;
    redirect_valid = 1'b0;
    chk("resume_req", {31'd0, ibus_req}, 32'd1);
    chk("resume_addr", ibus_addr, 32'h0000_3000);
    step;
    chk("resume_pc", inst_pc, 32'h0000_3000);
    chk("resume_fault", {31'd0, inst_fault}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4002;
    step;
    redirect_valid = 1'b0;
`ifdef KAIRO_FETCH_MISALIGN_EN
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_flag", {31'd0, inst_misalign}, 32'd1);
    chk("mis_pc", inst_pc, 32'h0000_4002);
    chk("mis_req", {31'd0, ibus_req}, 32'd0);
`else
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    chk("mis_addr", ibus_addr, 32'h0000_4000);
    step;
    chk("mis_pc", inst_pc, 32'h0000_4000);
    chk("mis_flag", {31'd0, inst_misalign}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kairo_fetch.md
# kairo_fetch

Instruction fetch stage for the Kairo RV32 core; sits directly upstream of the instruction decoder and supplies its 32-bit instruction word. Maintains the fetch PC, issues single-outstanding requests on the instruction bus, and buffers up to two fetched words with their PCs in a small FIFO. Accepts PC redirects from execute (branch, jump, trap, mret), flushing stale words, and tags bus errors as fetch faults.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- CLK  in  1  core clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REDIRECT_VALID  in  1  load new fetch PC this cycle.
- REDIRECT_PC  in  32  redirect target.
- INST_READY  in  1  consumer accepts head entry.
- INST_VALID  out  1  head entry valid.
- INST_CODE  out  32  instruction word to decoder.
- INST_PC  out  32  address of INST_CODE.
- INST_FAULT  out  1  head entry is a bus-error fault.
- INST_MISALIGN  out  1  head entry is a misaligned-target fault.
- IBUS_REQ  out  1  fetch request.
- IBUS_ADDR  out  32  word-aligned request address.
- IBUS_ACK  in  1  request complete; RDATA/ERR valid.
- IBUS_RDATA  in  32  fetched word.
- IBUS_ERR  in  1  bus error, qualified by ACK.

## Operation
- Bus rule: once IBUS_REQ rises, REQ and ADDR held stable until the cycle IBUS_ACK=1; ACK may arrive same cycle as REQ; one request outstanding max.
- FIFO: 2 entries of {code, pc, fault, misalign}; push on ACK (non-discarded); pop on INST_VALID & INST_READY; push and pop same cycle allowed at count 1 or 2.
- New request raised only when FSM in FETCH and count < 2 (registered count, no combinational READY→REQ path).
- Fetch PC advances by 4 on each non-discarded ACK; wraps 32'hFFFF_FFFC → 32'h0000_0000.
- FSM states: FETCH (normal), DRAIN (outstanding request must complete, data discarded), HALT (after fault, no requests).
- FETCH: REDIRECT with no request outstanding or ACK this cycle → FIFO cleared, PC <= target, stay FETCH. REDIRECT with request pending (REQ=1, ACK=0) → FIFO cleared, target latched, go DRAIN.
- DRAIN: on ACK discard data; next cycle FETCH. REDIRECT in DRAIN overwrites latched target.
- Fault: ACK with IBUS_ERR → push entry with code 32'h0000_0000, FAULT=1; go HALT. HALT exits only on REDIRECT (→ FETCH).
- Redirect has priority over handshake: in a REDIRECT cycle, a coincident pop or ACK push is dropped.
- INST_CODE, INST_PC, INST_FAULT, INST_MISALIGN driven 0 whenever INST_VALID=0.

## Timing
- Reset: INST_VALID 0, INST_CODE/PC/FAULT/MISALIGN 0, IBUS_REQ 0, IBUS_ADDR RESET_VECTOR, FIFO empty, state FETCH; outstanding request abandoned.
- First cycle with RST_N=1: IBUS_REQ=1, IBUS_ADDR=RESET_VECTOR.
- ACK at cycle N → INST_VALID=1 at N+1 (1-cycle latency).
- REDIRECT at cycle N (no pending request) → INST_VALID=0 at N+1, IBUS_REQ=1 with ADDR=target at N+1.
- Zero-wait bus, READY held 1: sustained 1 instruction/cycle.
- Backpressure: READY=0 with count=2 → REQ low until a pop.

## Configuration
- KAIRO_FETCH_MISALIGN_EN defined: REDIRECT_PC[1:0] != 0 → no bus request; push entry {code 0, pc target, MISALIGN=1}; go HALT.
- Undefined: REDIRECT_PC[1:0] forced to 00; INST_MISALIGN tied 0.

## Test plan
- Reset release, RESET_VECTOR=32'h0000_1000, zero-wait ACK, READY=1 → INST_PC 0x1000, 0x1004, 0x1008 on consecutive cycles, first valid 1 cycle after first ACK.
- READY=0 for 5 cycles → exactly 2 words buffered, REQ low; READY=1 → words 0x1000, 0x1004 delivered in order, no loss.
- ACK delayed 3 cycles, REDIRECT to 0x2000 during wait → ADDR held stale until ACK, data discarded, next REQ ADDR=0x2000, first INST_PC=0x2000.
- ACK with IBUS_ERR at 0x1008 → entry FAULT=1, CODE=0, PC=0x1008; no further REQ until REDIRECT to 0x3000 resumes fetch.
- PC wrap: RESET_VECTOR=32'hFFFF_FFF8 → INST_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
- REDIRECT to 0x4002: with KAIRO_FETCH_MISALIGN_EN → MISALIGN=1, PC=0x4002, no REQ; without → fetch ADDR=0x4000.
